// File: rtl/fsk_mod.sv
// fsk_mod -- continuous-phase 2FSK modulator.
//
// Paces the upstream PN code generator with a one-cycle symbol strobe,
// captures the returned code bit one clock later, and steps a phase
// accumulator by one of two tuning words. The top 8 phase bits address a
// quarter-wave sine LUT (folded to a full wave) to give offset-binary DAC
// samples.
//
// Optional build macro: FSK_PHASE_RESET_EN
//   defined   -> on the edge after a capture that changes the code bit the
//                accumulator loads 0 (zero-phase symbol starts).
//   undefined -> purely continuous phase, the accumulator is never reloaded.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   run enable (gates accumulator and symbol counter)
//   code       in   code bit from the upstream generator
//   sym_tick   out  one-cycle symbol strobe (upstream generator enable)
//   freq_sel   out  latched code bit (0 -> FTW0, 1 -> FTW1)
//   dout       out  8-bit sine sample, offset binary (128 = mid-scale)
//   dout_valid out  dout derives from a phase advanced under en
module fsk_mod #(
  parameter int unsigned PHASE_W = 24,
  parameter logic [PHASE_W-1:0] FTW0 = PHASE_W'(24'h020000),
  parameter logic [PHASE_W-1:0] FTW1 = PHASE_W'(24'h040000),
  parameter int unsigned SYM_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       code,
  output logic       sym_tick,
  output logic       freq_sel,
  output logic [7:0] dout,
  output logic       dout_valid
);

  logic [PHASE_W-1:0] acc_r;
  logic [15:0]        sym_cnt_r;
  logic [6:0]         mag_r;
  logic               p7_r;
  logic [2:0]         vld_r;
  logic [PHASE_W-1:0] ftw_s;
  logic [7:0]         p_s;
  logic [5:0]         idx_s;

  // Quarter-wave table: round(127*sin(2*pi*(i+0.5)/256)), i = 0..63.
  // The half-step offset keeps the folded wave symmetric about 127.5.
  function automatic logic [6:0] q_lut(input logic [5:0] i);
    logic [6:0] q;
    case (i)
      6'd0:  q = 7'd2;   6'd1:  q = 7'd5;   6'd2:  q = 7'd8;   6'd3:  q = 7'd11;
      6'd4:  q = 7'd14;  6'd5:  q = 7'd17;  6'd6:  q = 7'd20;  6'd7:  q = 7'd23;
      6'd8:  q = 7'd26;  6'd9:  q = 7'd29;  6'd10: q = 7'd32;  6'd11: q = 7'd35;
      6'd12: q = 7'd38;  6'd13: q = 7'd41;  6'd14: q = 7'd44;  6'd15: q = 7'd47;
      6'd16: q = 7'd50;  6'd17: q = 7'd53;  6'd18: q = 7'd56;  6'd19: q = 7'd58;
      6'd20: q = 7'd61;  6'd21: q = 7'd64;  6'd22: q = 7'd67;  6'd23: q = 7'd69;
      6'd24: q = 7'd72;  6'd25: q = 7'd74;  6'd26: q = 7'd77;  6'd27: q = 7'd79;
      6'd28: q = 7'd82;  6'd29: q = 7'd84;  6'd30: q = 7'd86;  6'd31: q = 7'd89;
      6'd32: q = 7'd91;  6'd33: q = 7'd93;  6'd34: q = 7'd95;  6'd35: q = 7'd97;
      6'd36: q = 7'd99;  6'd37: q = 7'd101; 6'd38: q = 7'd103; 6'd39: q = 7'd105;
      6'd40: q = 7'd106; 6'd41: q = 7'd108; 6'd42: q = 7'd110; 6'd43: q = 7'd111;
      6'd44: q = 7'd113; 6'd45: q = 7'd114; 6'd46: q = 7'd115; 6'd47: q = 7'd117;
      6'd48: q = 7'd118; 6'd49: q = 7'd119; 6'd50: q = 7'd120; 6'd51: q = 7'd121;
      6'd52: q = 7'd122; 6'd53: q = 7'd123; 6'd54: q = 7'd124; 6'd55: q = 7'd124;
      6'd56: q = 7'd125; 6'd57: q = 7'd125; 6'd58: q = 7'd126; 6'd59: q = 7'd126;
      6'd60: q = 7'd127; 6'd61: q = 7'd127; 6'd62: q = 7'd127; 6'd63: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Tuning word select and quarter-wave fold of the phase MSBs.
  always_comb begin
    ftw_s = FTW0;
    if (freq_sel) ftw_s = FTW1;
    else          ftw_s = FTW0;
    p_s = acc_r[PHASE_W-1 -: 8];
    if (p_s[6]) idx_s = ~p_s[5:0];
    else        idx_s = p_s[5:0];
  end

  // Symbol counter and strobe; both frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_r <= 16'd0;
      sym_tick  <= 1'b0;
    end else if (en) begin
      if (sym_cnt_r == 16'(SYM_DIV - 1)) begin
        sym_cnt_r <= 16'd0;
        sym_tick  <= 1'b1;
      end else begin
        sym_cnt_r <= sym_cnt_r + 16'd1;
        sym_tick  <= 1'b0;
      end
    end else begin
      sym_tick <= 1'b0;
    end
  end

  // Code capture one clock after the strobe, so the upstream falling-edge
  // update has settled. Captures even when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        freq_sel <= 1'b0;
    else if (sym_tick) freq_sel <= code;
    else               freq_sel <= freq_sel;
  end

`ifdef FSK_PHASE_RESET_EN
  logic chg_r;

  // Flags a capture that changes the code bit; the accumulator zeroes next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg_r <= 1'b0;
    else        chg_r <= sym_tick && (code != freq_sel);
  end
`endif

  // Phase accumulator; the tuning word follows freq_sel as it was before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_r <= '0;
`ifdef FSK_PHASE_RESET_EN
    else if (chg_r) acc_r <= '0;
`endif
    else if (en)    acc_r <= acc_r + ftw_s;
    else            acc_r <= acc_r;
  end

  // Free-running sine pipeline (LUT stage then output stage) plus valid shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_r <= 7'd0;
      p7_r  <= 1'b0;
      dout  <= 8'd128;
      vld_r <= 3'd0;
    end else begin
      mag_r <= q_lut(idx_s);
      p7_r  <= p_s[7];
      dout  <= p7_r ? (8'd127 - {1'b0, mag_r}) : (8'd128 + {1'b0, mag_r});
      vld_r <= {vld_r[1:0], en};
    end
  end

  assign dout_valid = vld_r[2];

endmodule
